// File: rtl/bcjr_alpha_unit_if.sv
// trellis_if: trellis description used by bcjr_alpha_unit.
//   next_state[s][u] : to-state reached from state s with input symbol u
//   outputs[s][u]    : code-bit word emitted on that branch (bit b = code bit b)
// master drives the tables, slave (the alpha unit) reads them.
interface trellis_if #(
  parameter int unsigned STATES      = 4,
  parameter int unsigned INPUT_BITS  = 1,
  parameter int unsigned OUTPUT_BITS = 2
);
  localparam int unsigned BRANCHES = 1 << INPUT_BITS;
  localparam int unsigned SW       = (STATES > 1) ? $clog2(STATES) : 1;

  logic [STATES-1:0][BRANCHES-1:0][SW-1:0]          next_state;
  logic [STATES-1:0][BRANCHES-1:0][OUTPUT_BITS-1:0] outputs;

  modport master (output next_state, output outputs);
  modport slave  (input  next_state, input  outputs);
endinterface

// File: rtl/bcjr_alpha_unit.sv
// bcjr_alpha_unit: max-log BCJR forward (alpha) recursion for one frame.
// A start pulse in IDLE writes the initial vector to address 0, then each
// accepted LLR beat produces the next alpha vector one cycle later at
// addresses 1..SYMBOLS; done pulses with the final write.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   trellis          trellis_if.slave: next-state / output tables (binary input)
//   start            frame-start request (honoured only in IDLE)
//   in_valid/ready   LLR beat handshake
//   llr_in           OUTPUT_BITS signed LLRs, index b = code bit b
//   alpha_wr_*       alpha store write port (step index, alpha vector)
//   done             one-cycle pulse with the last write
// Optional: define BCJR_ALPHA_NORM_EN to normalise each vector to max 0.
module bcjr_alpha_unit #(
  parameter int unsigned STATES      = 4,
  parameter int unsigned SYMBOLS     = 10,
  parameter int unsigned OUTPUT_BITS = 2,
  parameter int unsigned LLR_W       = 8,
  parameter int unsigned METRIC_W    = 12
) (
  input  logic                                  clk,
  input  logic                                  reset,
  trellis_if.slave                              trellis,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [OUTPUT_BITS-1:0][LLR_W-1:0]     llr_in,
  output logic                                  alpha_wr_en,
  output logic [$clog2(SYMBOLS+1)-1:0]          alpha_wr_addr,
  output logic [STATES-1:0][METRIC_W-1:0]       alpha_wr_data,
  output logic                                  done
);
  localparam int unsigned AW       = $clog2(SYMBOLS+1);
  localparam int unsigned SW       = (STATES > 1) ? $clog2(STATES) : 1;
  localparam int unsigned BRANCHES = 2;
  localparam int unsigned NQ       = 1 << OUTPUT_BITS;
  // Branch metrics are kept wide enough that the sum of OUTPUT_BITS LLRs never wraps.
  localparam int unsigned BM_W     = LLR_W + $clog2(OUTPUT_BITS) + 1;
  localparam int unsigned SUM_W    = ((METRIC_W > BM_W) ? METRIC_W : BM_W) + 1;
  localparam int          MAX_I    = (2 ** (METRIC_W-1)) - 1;
  localparam int          NEG_I    = -(2 ** (METRIC_W-2));

  localparam logic signed [METRIC_W-1:0] MET_MAX = METRIC_W'(MAX_I);
  localparam logic signed [METRIC_W-1:0] NEG_INF = METRIC_W'(NEG_I);
  localparam logic signed [SUM_W-1:0]    SUM_MAX = SUM_W'(MAX_I);
  localparam logic signed [SUM_W-1:0]    SUM_NEG = SUM_W'(NEG_I);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t                          state_q;
  logic [AW-1:0]                   cnt_q;
  logic [STATES-1:0][METRIC_W-1:0] alpha_q;
  logic                            in_ready_q;
  logic                            wr_en_q;
  logic [AW-1:0]                   wr_addr_q;
  logic [STATES-1:0][METRIC_W-1:0] wr_data_q;
  logic                            done_q;

  logic signed [LLR_W-1:0]         llr_s;
  logic signed [BM_W-1:0]          bm [NQ];
  logic signed [METRIC_W-1:0]      a_s;
  logic signed [SUM_W-1:0]         sum;
  logic signed [METRIC_W-1:0]      cand;
  logic signed [METRIC_W-1:0]      best [STATES];
  logic [STATES-1:0][METRIC_W-1:0] alpha_d;
  logic [STATES-1:0][METRIC_W-1:0] init_vec;
`ifdef BCJR_ALPHA_NORM_EN
  logic signed [METRIC_W-1:0]      mx;
  logic signed [METRIC_W:0]        diff;
`endif

  always_comb begin
    for (int unsigned s = 0; s < STATES; s++) begin
      init_vec[s] = (s == 0) ? '0 : NEG_INF;
    end
  end

  always_comb begin
    llr_s = '0;
    a_s   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned q = 0; q < NQ; q++) begin
      bm[q] = '0;
      for (int unsigned b = 0; b < OUTPUT_BITS; b++) begin
        llr_s = llr_in[b];
        if (((q >> b) & 32'd1) != 0) bm[q] = bm[q] + BM_W'(llr_s);
        else                         bm[q] = bm[q] - BM_W'(llr_s);
      end
    end
    // Every candidate is saturated into [NEG_INF, MAX], so NEG_INF is a safe
    // starting point for the max and the result for states with no predecessor.
    for (int unsigned s = 0; s < STATES; s++) begin
      best[s] = NEG_INF;
      for (int unsigned j = 0; j < STATES; j++) begin
        for (int unsigned p = 0; p < BRANCHES; p++) begin
          if (trellis.next_state[j][p] == SW'(s)) begin
            a_s = alpha_q[j];
            sum = SUM_W'(a_s) + SUM_W'(bm[trellis.outputs[j][p]]);
            if (sum > SUM_MAX)      cand = MET_MAX;
            else if (sum < SUM_NEG) cand = NEG_INF;
            else                    cand = sum[METRIC_W-1:0];
            if (cand > best[s]) best[s] = cand;
          end
        end
      end
    end
`ifdef BCJR_ALPHA_NORM_EN
    mx   = NEG_INF;
    diff = '0;
    for (int unsigned s = 0; s < STATES; s++) begin
      if (best[s] > mx) mx = best[s];
    end
    for (int unsigned s = 0; s < STATES; s++) begin
      diff = (METRIC_W+1)'(best[s]) - (METRIC_W+1)'(mx);
      if (diff < (METRIC_W+1)'(NEG_INF)) alpha_d[s] = NEG_INF;
      else                               alpha_d[s] = diff[METRIC_W-1:0];
    end
`else
    for (int unsigned s = 0; s < STATES; s++) begin
      alpha_d[s] = best[s];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alpha_q    <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            alpha_q   <= init_vec;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= init_vec;
          end
        end
        S_INIT: begin
          state_q    <= S_RUN;
          in_ready_q <= 1'b1;
        end
        S_RUN: begin
          if (in_valid && in_ready_q) begin
            alpha_q   <= alpha_d;
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q + AW'(1);
            wr_data_q <= alpha_d;
            cnt_q     <= cnt_q + AW'(1);
            // The last write lands in the DONE cycle, so done rides along with it.
            if (cnt_q == AW'(SYMBOLS-1)) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign alpha_wr_en   = wr_en_q;
  assign alpha_wr_addr = wr_addr_q;
  assign alpha_wr_data = wr_data_q;
  assign done          = done_q;
endmodule

// File: tb/tb_bcjr_alpha_unit.sv
// Randomised scoreboard bench for bcjr_alpha_unit on the 4-state RSC (7/5)
// trellis at METRIC_W=10 so that saturation is reachable.
module tb_bcjr_alpha_unit;
  localparam int ST = 4;
  localparam int SY = 10;
  localparam int OB = 2;
  localparam int LW = 8;
  localparam int MW = 10;
  localparam int AW = $clog2(SY+1);
  localparam int MAXM = (2 ** (MW-1)) - 1;
  localparam int NEGM = -(2 ** (MW-2));

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready;
  logic [OB-1:0][LW-1:0] llr_in;
  logic alpha_wr_en, done;
  logic [AW-1:0] alpha_wr_addr;
  logic [ST-1:0][MW-1:0] alpha_wr_data;

  trellis_if #(.STATES(ST), .INPUT_BITS(1), .OUTPUT_BITS(OB)) tif ();

  bcjr_alpha_unit #(.STATES(ST), .SYMBOLS(SY), .OUTPUT_BITS(OB), .LLR_W(LW), .METRIC_W(MW)) dut (
    .clk(clk), .reset(reset), .trellis(tif), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .llr_in(llr_in), .alpha_wr_en(alpha_wr_en),
    .alpha_wr_addr(alpha_wr_addr), .alpha_wr_data(alpha_wr_data), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int addr;
    logic [ST-1:0][MW-1:0] data;
    bit done;
  } exp_t;
  exp_t sb[$];

  int ns_m [ST][2];
  int out_m[ST][2];
  int alpha_m[ST];
  int llr_cur[OB];

  function automatic void chk(string name, longint got, longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endfunction

  function automatic int satm(int x);
    if (x > MAXM) return MAXM;
    if (x < NEGM) return NEGM;
    return x;
  endfunction

  // Max-log forward step computed straight from the trellis tables.
  function automatic void model_beat();
    int bm[1 << OB];
    int nw[ST];
    int mx;
    for (int q = 0; q < (1 << OB); q++) begin
      bm[q] = 0;
      for (int b = 0; b < OB; b++) bm[q] += ((q >> b) & 1) ? llr_cur[b] : -llr_cur[b];
    end
    for (int s = 0; s < ST; s++) begin
      nw[s] = NEGM;
      for (int j = 0; j < ST; j++)
        for (int p = 0; p < 2; p++)
          if (ns_m[j][p] == s && satm(alpha_m[j] + bm[out_m[j][p]]) > nw[s])
            nw[s] = satm(alpha_m[j] + bm[out_m[j][p]]);
    end
`ifdef BCJR_ALPHA_NORM_EN
    mx = nw[0];
    for (int s = 1; s < ST; s++) if (nw[s] > mx) mx = nw[s];
    for (int s = 0; s < ST; s++) nw[s] = (nw[s] - mx < NEGM) ? NEGM : nw[s] - mx;
`else
    mx = 0;
`endif
    for (int s = 0; s < ST; s++) alpha_m[s] = nw[s];
  endfunction

  function automatic void push_exp(int c, int addr, bit d);
    exp_t e;
    e.cyc = c;
    e.addr = addr;
    e.done = d;
    for (int s = 0; s < ST; s++) e.data[s] = MW'(alpha_m[s]);
    sb.push_back(e);
  endfunction

  // Monitor: every write must match the oldest expectation, at the expected cycle.
  always @(negedge clk) begin
    if (alpha_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write (cycle %0d)", alpha_wr_addr, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", alpha_wr_addr, e.addr);
        chk("write_data", alpha_wr_data, e.data);
        chk("done_with_write", done, e.done);
      end
    end else begin
      if (done !== 1'b0) chk("done_without_write", done, 0);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: got none expected addr %0d at cycle %0d", sb[0].addr, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    alpha_m[0] = 0;
    for (int s = 1; s < ST; s++) alpha_m[s] = NEGM;
    push_exp(cyc + 1, 0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("ready_after_init", in_ready, 1);
  endtask

  // mode: 0 zeros, 1 +10, 2 +127, 3 random, 4 -128; vpat: 0 always, 1 1-0-0, 2 random
  task automatic feed(int nbeats, int mode, int vpat, bit poke_start);
    int acc = 0;
    int g = 0;
    while (acc < nbeats && g < 300) begin
      bit v;
      case (vpat)
        0: v = 1'b1;
        1: v = (g % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      for (int b = 0; b < OB; b++) begin
        case (mode)
          0: llr_cur[b] = 0;
          1: llr_cur[b] = 10;
          2: llr_cur[b] = 127;
          4: llr_cur[b] = -128;
          default: llr_cur[b] = int'($urandom_range(0, 255)) - 128;
        endcase
        llr_in[b] = LW'(llr_cur[b]);
      end
      in_valid = v;
      start = poke_start && (g == 3);
      if (v && in_ready === 1'b1) begin
        model_beat();
        push_exp(cyc + 1, acc + 1, (acc + 1) == SY);
        acc++;
      end
      tick();
      g++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("beats_accepted", acc, nbeats);
  endtask

  task automatic full_frame(int mode, int vpat, bit poke_start);
    do_start();
    wait_ready();
    feed(SY, mode, vpat, poke_start);
    chk("ready_low_after_frame", in_ready, 0);
    tick();
    tick();
  endtask

  initial begin
    for (int s = 0; s < ST; s++) begin
      for (int u = 0; u < 2; u++) begin
        int r1, r2, a, par;
        r1 = (s >> 1) & 1;
        r2 = s & 1;
        a = u ^ r1 ^ r2;
        par = a ^ r2;
        ns_m[s][u] = (a << 1) | r1;
        out_m[s][u] = (par << 1) | u;
        tif.next_state[s][u] = 2'(ns_m[s][u]);
        tif.outputs[s][u] = 2'(out_m[s][u]);
      end
    end
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    llr_in = '0;
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_wr_en", alpha_wr_en, 0);
    chk("reset_wr_addr", alpha_wr_addr, 0);
    chk("reset_wr_data", alpha_wr_data, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    tick();

    full_frame(0, 0, 1'b0);
    full_frame(1, 0, 1'b0);
    full_frame(2, 0, 1'b0);
    full_frame(4, 0, 1'b0);
    full_frame(3, 1, 1'b0);
    full_frame(3, 2, 1'b1);
    full_frame(3, 0, 1'b0);

    // Abandon a frame after 4 beats; no further writes and no done may follow.
    do_start();
    wait_ready();
    feed(4, 3, 0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("abort_ready_low", in_ready, 0);
    chk("abort_queue_drained", sb.size(), 0);

    // Reset wins over start and in_valid in the same cycle.
    reset = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("reset_priority_ready", in_ready, 0);

    full_frame(3, 2, 1'b0);
    full_frame(2, 1, 1'b0);

    repeat (3) tick();
    chk("final_queue_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
